op_queue: RTL and testbench

Operand queue sitting directly upstream of the ALU and three-stage pipeline in pd0. It buffers {op1, op2, sel} operation triples from a producer with a valid/ready handshake and presents them in FIFO order to the execute stage, decoupling producer bursts from consumer stalls. Storage is a DEPTH-entry circular buffer with first-word-fall-through output.

---
 rtl/op_queue.sv | 95 +++++++++
 tb/tb_op_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/op_queue.sv
// op_queue: DEPTH-entry first-word-fall-through queue of {op1, op2, sel} triples feeding the ALU.
// Define OP_QUEUE_STATS_EN to add the stall_cnt_o producer-stall counter.
module op_queue #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DWIDTH-1:0]        op1_i,
  input  logic [DWIDTH-1:0]        op2_i,
  input  logic [1:0]               sel_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DWIDTH-1:0]        op1_o,
  output logic [DWIDTH-1:0]        op2_o,
  output logic [1:0]               sel_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
`ifdef OP_QUEUE_STATS_EN
  ,
  output logic [15:0]              stall_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;
    logic [1:0]        sel;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  // Gating with rst keeps the producer stalled for the whole reset pulse.
  assign ready_o = !full_o && !rst;
  assign valid_o = !empty_o;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    head = '0;
    if (!empty_o) head = mem[rd_ptr];
  end

  assign op1_o = head.op1;
  assign op2_o = head.op2;
  assign sel_o = head.sel;

  // Power-of-two DEPTH lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the storage array is reset too, so stale operands never reach the ALU after a flush.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{op1: op1_i, op2: op2_i, sel: sel_i};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef OP_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (valid_i && !ready_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_op_queue.sv
// Scoreboard bench for op_queue: stimulus enqueues expected triples, a monitor checks every pop.
module tb_op_queue;

  localparam int DWIDTH = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;
    logic [1:0]        sel;
  } trip_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   valid_i = 1'b0;
  logic                   ready_o;
  logic [DWIDTH-1:0]      op1_i = '0;
  logic [DWIDTH-1:0]      op2_i = '0;
  logic [1:0]             sel_i = '0;
  logic                   valid_o;
  logic                   ready_i = 1'b0;
  logic [DWIDTH-1:0]      op1_o;
  logic [DWIDTH-1:0]      op2_o;
  logic [1:0]             sel_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   full_o;
  logic                   empty_o;
`ifdef OP_QUEUE_STATS_EN
  logic [15:0]            stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  trip_t exp_q[$];

  op_queue #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .op1_i(op1_i), .op2_i(op2_i), .sel_i(sel_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .op1_o(op1_o), .op2_o(op2_o), .sel_o(sel_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
`ifdef OP_QUEUE_STATS_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop occurs at the next rising edge whenever valid_o && ready_i here.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 64'(op1_o), 64'hDEAD);
      end else begin
        trip_t e;
        e = exp_q.pop_front();
        check("pop_op1", 64'(op1_o), 64'(e.op1));
        check("pop_op2", 64'(op2_o), 64'(e.op2));
        check("pop_sel", 64'(sel_o), 64'(e.sel));
      end
    end
  end

  // Drive one triple, hold it until accepted (bounded), then release valid_i.
  task automatic push_one(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b, input logic [1:0] s);
    bit ok = 1'b0;
    valid_i = 1'b1; op1_i = a; op2_i = b; sel_i = s;
    exp_q.push_back('{op1: a, op2: b, sel: s});
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; break; end
    end
    check("push_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (empty_o) break;
    end
    check("drain_empty", 64'(empty_o), 64'd1);
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_op1", 64'(op1_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(ready_o), 64'd1);

    // Single push with consumer ready: visible next cycle, popped, empty after.
    @(posedge clk); #1;
    ready_i = 1'b1;
    push_one(32'd5, 32'd3, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_empty", 64'(empty_o), 64'd1);
    check("single_op1_zero", 64'(op1_o), 64'd0);
    check("single_sel_zero", 64'(sel_o), 64'd0);
    @(posedge clk); #1;
    ready_i = 1'b0;

    // Fill to DEPTH with consumer stalled.
    for (int i = 1; i <= 4; i++) push_one(DWIDTH'(i), DWIDTH'(i * 10), 2'(i));
    @(negedge clk);
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_count", 64'(count_o), 64'd4);
    check("fill_ready", 64'(ready_o), 64'd0);
    check("fill_head", 64'(op1_o), 64'd1);

    // Fifth triple held by producer for 7 stall cycles, not accepted.
    @(posedge clk); #1;
    valid_i = 1'b1; op1_i = 32'd5; op2_i = 32'd50; sel_i = 2'd1;
    exp_q.push_back('{op1: 32'd5, op2: 32'd50, sel: 2'd1});
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("held_count", 64'(count_o), 64'd4);
`ifdef OP_QUEUE_STATS_EN
    check("stall_7", 64'(stall_cnt_o), 64'd7);
`endif
    ready_i = 1'b1;
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (ready_o) begin ok = 1'b1; break; end
      end
      check("held_accept_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    drain();

    // Sustained push+pop at count 2 across pointer wrap.
    push_one(32'd100, 32'd1000, 2'd0);
    push_one(32'd101, 32'd1001, 2'd1);
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op1_i = DWIDTH'(200 + i); op2_i = DWIDTH'(2000 + i); sel_i = 2'(i);
      exp_q.push_back('{op1: DWIDTH'(200 + i), op2: DWIDTH'(2000 + i), sel: 2'(i)});
      @(negedge clk);
      check("stream_count", 64'(count_o), 64'd2);
      check("stream_ready", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    @(negedge clk);
    check("stream_count_end", 64'(count_o), 64'd2);
    drain();

    // Full queue, push and pop in the same cycle: pop wins, push waits one cycle.
    for (int i = 0; i < 4; i++) push_one(DWIDTH'(300 + i), DWIDTH'(3000 + i), 2'(i));
    ready_i = 1'b1;
    valid_i = 1'b1; op1_i = 32'd304; op2_i = 32'd3004; sel_i = 2'd3;
    exp_q.push_back('{op1: 32'd304, op2: 32'd3004, sel: 2'd3});
    @(negedge clk);
    check("fullpp_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    ready_i = 1'b0;
    @(negedge clk);
    check("fullpp_count", 64'(count_o), 64'd3);
    check("fullpp_ready_next", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("fullpp_accepted", 64'(count_o), 64'd4);

    // Pop once to reach count 3, then reset mid-operation with a push in flight.
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    @(negedge clk);
    check("pre_rst_count", 64'(count_o), 64'd3);
    @(posedge clk); #1;
    valid_i = 1'b1; op1_i = 32'd999;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_op1", 64'(op1_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_lost_push", 64'(count_o), 64'd0);
    check("midrst_ready_held", 64'(ready_o), 64'd0);
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(ready_o), 64'd1);
    check("post_rst_empty", 64'(empty_o), 64'd1);

`ifdef OP_QUEUE_STATS_EN
    check("stall_rst", 64'(stall_cnt_o), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_one(DWIDTH'(400 + i), DWIDTH'(4000 + i), 2'(i));
    valid_i = 1'b1; op1_i = 32'd404;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stall_sat", 64'(stall_cnt_o), 64'hFFFF);
    valid_i = 1'b0;
    @(posedge clk); #1;
    drain();
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
